// File: rtl/seg7_mux_display.sv
// Purpose: multiplexed common-anode 7-segment driver; hex or decimal (double-dabble) rendering of a captured word.
// Latency: hex load -> display reg next edge; decimal load -> DATA_W busy cycles; seg/an/dp registered (+1 cycle).
// Backpressure: load is ignored while busy is high; nothing is queued.
// Ports: clk/reset (sync, active-high); value/load/mode capture the word; blank_lz, dp_mask live controls;
//        busy = conversion running; seg {g..a}, an (an[0] rightmost) and dp are all active-low.
module seg7_mux_display #(
    parameter int N_DIGITS    = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   value,
    input  logic                load,
    input  logic                mode,
    input  logic                blank_lz,
    input  logic [N_DIGITS-1:0] dp_mask,
    output logic                busy,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic                dp
);
    // BCD digits needed for DATA_W bits is ceil(DATA_W*log10(2)); one spare digit,
    // and never fewer than the displayed digits so the low slice always exists.
    localparam int BCD_RAW = (DATA_W * 302 + 999) / 1000 + 1;
    localparam int BCD_D   = (BCD_RAW > N_DIGITS) ? BCD_RAW : N_DIGITS;
    localparam int BCD_W   = BCD_D * 4;
    localparam int DISP_W  = N_DIGITS * 4;
    localparam int EXT_W   = (DATA_W > DISP_W) ? DATA_W : DISP_W;
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int REF_W   = $clog2(REFRESH_DIV);
    localparam int ITER_W  = $clog2(DATA_W);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [ITER_W-1:0]   r_iter;
    logic [DISP_W-1:0]   r_dig;
    logic                r_ovf;
    logic [REF_W-1:0]    r_ref_cnt;
    logic [IDX_W-1:0]    r_idx;

    logic [EXT_W-1:0]    w_val_ext;
    logic [BCD_W-1:0]    w_bcd_adj;
    logic [BCD_W-1:0]    w_bcd_nxt;
    logic                w_bcd_ovf;
    logic                w_last;
    logic [N_DIGITS-1:0] w_lz;
    logic                w_run;
    logic [3:0]          w_cur_dig;
    logic                w_blank;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'h0: f_glyph = 7'b1000000;
            4'h1: f_glyph = 7'b1111001;
            4'h2: f_glyph = 7'b0100100;
            4'h3: f_glyph = 7'b0110000;
            4'h4: f_glyph = 7'b0011001;
            4'h5: f_glyph = 7'b0010010;
            4'h6: f_glyph = 7'b0000010;
            4'h7: f_glyph = 7'b1111000;
            4'h8: f_glyph = 7'b0000000;
            4'h9: f_glyph = 7'b0010000;
            4'hA: f_glyph = 7'b0001000;
            4'hB: f_glyph = 7'b0000011;
            4'hC: f_glyph = 7'b1000110;
            4'hD: f_glyph = 7'b0100001;
            4'hE: f_glyph = 7'b0000110;
            default: f_glyph = 7'b0001110;
        endcase
    endfunction

    // Zero-extend so hex digits beyond DATA_W read as 0.
    assign w_val_ext = EXT_W'(value);
    assign w_last    = (r_iter == ITER_W'(DATA_W - 1));
    assign busy      = (r_state == S_CONV);

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next MSB.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < BCD_D; k++) begin
            if (r_bcd[k*4 +: 4] >= 4'd5) begin
                w_bcd_adj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
            end
        end
        w_bcd_nxt = {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};
        w_bcd_ovf = 1'b0;
        for (int k = N_DIGITS; k < BCD_D; k++) begin
            w_bcd_ovf = w_bcd_ovf | (w_bcd_nxt[k*4 +: 4] != 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (load && mode) w_state_nxt = S_CONV;
            S_CONV: if (w_last)       w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Conversion datapath and display register; the display register is only
    // written as a whole (hex capture or final conversion step).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
            r_dig  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        if (mode) begin
                            r_bin  <= value;
                            r_bcd  <= '0;
                            r_iter <= '0;
                        end else begin
                            r_dig <= w_val_ext[DISP_W-1:0];
                            r_ovf <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_bin  <= r_bin << 1;
                    r_bcd  <= w_bcd_nxt;
                    r_iter <= r_iter + ITER_W'(1);
                    if (w_last) begin
                        r_dig <= w_bcd_nxt[DISP_W-1:0];
                        r_ovf <= w_bcd_ovf;
                    end
                end
            endcase
        end
    end

    // Refresh counter and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref_cnt <= '0;
            r_idx     <= '0;
        end else if (r_ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            r_ref_cnt <= '0;
            r_idx     <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_ref_cnt <= r_ref_cnt + REF_W'(1);
        end
    end

    // w_lz[i]: digit i and everything above it are zero.
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_run   = w_run & (r_dig[i*4 +: 4] == 4'd0);
            w_lz[i] = w_run;
        end
    end

    assign w_cur_dig = r_dig[{r_idx, 2'b00} +: 4];
    // Overflow dashes are never blanked; digit 0 always shows.
    assign w_blank   = blank_lz & ~r_ovf & (r_idx != '0) & w_lz[r_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= 7'h7F;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            an  <= ~(N_DIGITS'(1) << r_idx);
            dp  <= ~dp_mask[r_idx];
            if (r_ovf) begin
                seg <= 7'b0111111;
            end else if (w_blank) begin
                seg <= 7'h7F;
            end else begin
                seg <= f_glyph(w_cur_dig);
            end
        end
    end
endmodule

// File: tb/tb_seg7_mux_display.sv
// Purpose: directed self-checking bench for seg7_mux_display (4 digits, 16-bit, refresh 4).
// Latency: stimulus driven 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: exercises load-while-busy rejection and reset mid-conversion.
module tb_seg7_mux_display;
    localparam int ND = 4;
    localparam int DW = 16;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] value = '0;
    logic          load = 1'b0;
    logic          mode = 1'b0;
    logic          blank_lz = 1'b0;
    logic [ND-1:0] dp_mask = '0;
    logic          busy;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          dp;

    int checks = 0;
    int failures = 0;

    seg7_mux_display #(.N_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .mode(mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy), .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [DW-1:0] v, input logic m);
        value = v;
        mode  = m;
        load  = 1'b1;
        tick;
        load  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick;
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Wait until digit i is enabled, then check its glyph.
    task automatic check_digit(input int i, input logic [6:0] exp, input string tag);
        logic [ND-1:0] want;
        logic found;
        want  = ~(ND'(1) << i);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick;
            if (an === want) found = 1'b1;
        end
        chk({tag, "_an"}, 32'(found), 32'd1);
        chk(tag, 32'(seg), 32'(exp));
    endtask

    initial begin
        int nb;

        // Reset held 3 cycles
        tick; tick; tick;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // Scan sequence with a decimal point on digit 2
        dp_mask = 4'b0100;
        reset = 1'b0;
        tick;
        chk("scan_e1", 32'(an), 32'hE);
        chk("scan_dp_off", 32'(dp), 32'd1);
        tick; tick; tick;
        chk("scan_e4", 32'(an), 32'hE);
        tick;
        chk("scan_e5", 32'(an), 32'hD);
        repeat (RD) tick;
        chk("scan_e9", 32'(an), 32'hB);
        chk("scan_dp_on", 32'(dp), 32'd0);
        repeat (RD) tick;
        chk("scan_e13", 32'(an), 32'h7);
        repeat (RD) tick;
        chk("scan_e17", 32'(an), 32'hE);
        dp_mask = '0;

        // Hex BEEF
        do_load(16'hBEEF, 1'b0);
        chk("hex_busy", 32'(busy), 32'd0);
        check_digit(3, 7'b0000011, "hex_d3");
        check_digit(2, 7'b0000110, "hex_d2");
        check_digit(1, 7'b0000110, "hex_d1");
        check_digit(0, 7'b0001110, "hex_d0");

        // Decimal 1234, busy exactly 16 cycles
        do_load(16'd1234, 1'b1);
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            tick;
        end
        chk("dec_busy_len", 32'(nb), 32'd16);
        check_digit(3, 7'b1111001, "d1234_d3");
        check_digit(2, 7'b0100100, "d1234_d2");
        check_digit(1, 7'b0110000, "d1234_d1");
        check_digit(0, 7'b0011001, "d1234_d0");

        // 9999 and 10000 (overflow, blanking suppressed)
        do_load(16'd9999, 1'b1);
        wait_idle("d9999_idle");
        check_digit(3, 7'b0010000, "d9999_d3");
        check_digit(0, 7'b0010000, "d9999_d0");
        blank_lz = 1'b1;
        do_load(16'd10000, 1'b1);
        wait_idle("d10000_idle");
        check_digit(3, 7'b0111111, "ovf_d3");
        check_digit(1, 7'b0111111, "ovf_d1");
        check_digit(0, 7'b0111111, "ovf_d0");

        // 7 with and without leading-zero blanking
        do_load(16'd7, 1'b1);
        wait_idle("d7_idle");
        check_digit(3, 7'h7F, "lz_d3");
        check_digit(2, 7'h7F, "lz_d2");
        check_digit(1, 7'h7F, "lz_d1");
        check_digit(0, 7'b1111000, "lz_d0");
        blank_lz = 1'b0;
        check_digit(3, 7'b1000000, "nolz_d3");
        check_digit(1, 7'b1000000, "nolz_d1");
        check_digit(0, 7'b1111000, "nolz_d0");

        // Second load during conversion is ignored
        do_load(16'd567, 1'b1);
        tick; tick;
        do_load(16'd42, 1'b1);
        chk("ign_busy", 32'(busy), 32'd1);
        wait_idle("ign_idle");
        check_digit(2, 7'b0010010, "ign_d2");
        check_digit(1, 7'b0000010, "ign_d1");
        check_digit(0, 7'b1111000, "ign_d0");

        // Reset mid-conversion
        do_load(16'd1234, 1'b1);
        tick; tick; tick;
        reset = 1'b1;
        tick;
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_an", 32'(an), 32'hF);
        reset = 1'b0;
        check_digit(3, 7'b1000000, "rmid_d3");
        check_digit(0, 7'b1000000, "rmid_d0");
        tick;
        chk("rmid_busy2", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
